// File: rtl/elapse_timer_pkg.sv
// Shared definitions for the elapse timer bank: channel state encoding and
// default sizing constants used by the top and the per-channel timers.
package elapse_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    localparam int DEFAULT_CNT_W    = 26;
    localparam int DEFAULT_PRESCALE = 40;
    localparam int PRESCALE_W       = 16;

endpackage

// File: rtl/elapse_timer_channel.sv
// One independent timer channel. Counts ticks from zero up to TermReg-1 and
// raises a one-clock timeout pulse when the terminal count is reached.
// Stop beats Start, and a valid Start beats a coincident expiry.
module elapse_timer_channel
    import elapse_timer_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
)
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] terminal,
    output logic             timeout,
    output logic             timeoutNext,
    output logic             busy
);

    chan_state_e      state;
    logic [CNT_W-1:0] elapsed;
    logic [CNT_W-1:0] elapsedInc;
    logic [CNT_W-1:0] termReg;
    logic             perReg;
    logic             startOk;
    logic             expire;

    // Decode the restart request, the terminal-count hit and the pulse to register next edge
    always_comb begin
        elapsedInc  = elapsed + CNT_W'(1);
        startOk     = start && (terminal != '0);
        expire      = (state == RUN) && tick && (elapsedInc == termReg);
        timeoutNext = expire && !stop && !startOk;
    end

    // Channel state, latched configuration, elapsed count and the registered pulse
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            elapsed <= '0;
            termReg <= '0;
            perReg  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= timeoutNext;
            if (stop) begin
                state   <= IDLE;
                elapsed <= '0;
            end else if (startOk) begin
                state   <= RUN;
                elapsed <= '0;
                termReg <= terminal;
                perReg  <= periodic;
            end else if ((state == RUN) && tick) begin
                if (expire) begin
                    elapsed <= '0;
                    if (!perReg) begin
                        state <= IDLE;
                    end
                end else begin
                    elapsed <= elapsedInc;
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: rtl/elapse_timer_bank.sv
// Bank of NUM_CH independent elapse timers sharing one terminal-count bus and
// one tick. Optional macro ELAPSE_TIMER_PRESCALE_EN enables a free-running
// prescaler producing one tick every PRESCALE clocks; without it every clock
// is a tick.
module elapse_timer_bank
    import elapse_timer_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int PRESCALE = DEFAULT_PRESCALE
)
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] Start,
    input  logic [NUM_CH-1:0] Stop,
    input  logic [NUM_CH-1:0] Periodic,
    input  logic [CNT_W-1:0]  Terminal,
    output logic [NUM_CH-1:0] Timeout,
    output logic [NUM_CH-1:0] Busy,
    output logic              TimeoutAny
);

    logic              tick;
    logic [NUM_CH-1:0] timeoutNextVec;

    if (PRESCALE < 2 || PRESCALE > 65535) begin : gBadPrescale
        $error("elapse_timer_bank: PRESCALE must be in 2..65535");
    end

`ifdef ELAPSE_TIMER_PRESCALE_EN
    localparam logic [PRESCALE_W-1:0] PRE_MAX = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] preCnt;

    // Free-running prescaler that wraps after PRE_MAX and ticks on the wrap clock
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            preCnt <= '0;
        end else if (preCnt == PRE_MAX) begin
            preCnt <= '0;
        end else begin
            preCnt <= preCnt + PRESCALE_W'(1);
        end
    end

    assign tick = (preCnt == PRE_MAX);
`else
    assign tick = 1'b1;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChannel
        elapse_timer_channel #(
            .CNT_W (CNT_W)
        ) uChannel (
            .Clock       (Clock),
            .Reset       (Reset),
            .tick        (tick),
            .start       (Start[ch]),
            .stop        (Stop[ch]),
            .periodic    (Periodic[ch]),
            .terminal    (Terminal),
            .timeout     (Timeout[ch]),
            .timeoutNext (timeoutNextVec[ch]),
            .busy        (Busy[ch])
        );
    end

    // Aggregate pulse registered from the same next-state terms so it lines up with Timeout
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            TimeoutAny <= 1'b0;
        end else begin
            TimeoutAny <= |timeoutNextVec;
        end
    end

endmodule
